shift_reg_n: RTL
================

// Module: shift_reg_n
// PURPOSE
//   Parametrised WIDTH-bit register bank, the multi-bit successor to the single-bit dff.
//   Manual modes: hold, shift-left, shift-right, parallel load.
//   Built-in serial-transfer sequencer: start shifts the word out LSB-first on sout over
//   WIDTH cycles while capturing sin_l, with a busy/done handshake.
//   Serial front-end building block for the mdac datapath.
// PARAMETERS
//   WIDTH      8     register width in bits; legal range WIDTH >= 2
//   RESET_VAL  0     value loaded into q on reset (WIDTH bits)
// PORTS
//   clk      in   1      clock; all state updates on rising edge
//   reset    in   1      synchronous reset, active-high
//   en       in   1      enables manual mode operation (idle only)
//   mode     in   2      00 hold, 01 shift-left, 10 shift-right, 11 parallel load
//   d        in   WIDTH  parallel load data
//   sin_l    in   1      serial in at MSB (shift-right and transfer)
//   sin_r    in   1      serial in at LSB (shift-left)
//   start    in   1      request serial transfer (1-cycle pulse or level)
//   q        out  WIDTH  register contents
//   sout     out  1      serial out = q[0]
//   busy     out  1      high while the transfer shifts
//   done     out  1      1-cycle pulse after the last transfer shift
// BEHAVIOUR
//   Reset (sampled at edge, highest priority, aborts any transfer):
//   - q=RESET_VAL, busy=0, done=0, bit counter=0, FSM=IDLE.
//   sout is always q[0]: driven from the register, no combinational path from inputs.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE / DONE (identical input handling):
//   - start=1: next state SHIFT, counter=0, q unchanged. start has priority over en/mode.
//   - else en=1: apply mode
//     - 01: q <= {q[W-2:0], sin_r}
//     - 10: q <= {sin_l, q[W-1:1]}
//     - 11: q <= d
//     - 00: hold
//   - else en=0: hold.
//   - DONE always leaves after one cycle: to SHIFT if start, else to IDLE.
//   SHIFT:
//   - every edge: q <= {sin_l, q[W-1:1]}, counter++.
//   - en, mode and start are ignored; start is not queued.
//   - after the WIDTH-th shift (counter reaches WIDTH-1 at that edge): next state DONE.
//   Output timing:
//   - busy=1 iff state==SHIFT; done=1 iff state==DONE. Both are decoded from registered state.
//   Latency, for start sampled at edge k:
//   - busy high from after edge k until edge k+WIDTH.
//   - shifts occur at edges k+1..k+WIDTH.
//   - done high for the single cycle after edge k+WIDTH.
//   - sout shows original bit i during busy cycle i (i = 0..WIDTH-1).
//   Counter width is $clog2(WIDTH); it never wraps inside a transfer.
//   Back-to-back transfers: start held high during DONE relaunches, giving one idle/done
//   cycle between transfers.
// TESTING
//   1 Reset: assert reset 2 cycles, RESET_VAL=0 -> q=00, busy=0, done=0, sout=0.
//   2 Manual ops (WIDTH=8):
//     - load d=A5 (en=1, mode=11) -> q=A5
//     - shl, sin_r=1 -> q=4B
//     - reload A5, shr, sin_l=0 -> q=52
//     - en=0 with mode=11, d=FF -> q holds 52
//   3 Transfer: q=A5, pulse start, sin_l=1 ->
//     - busy high 8 cycles; sout per busy cycle = 1,0,1,0,0,1,0,1
//     - then done high 1 cycle, busy=0, q=FF
//   4 Ignore while busy: during transfer drive en=1, mode=11, d=00, start=1 ->
//     - sout sequence and 8-cycle busy unchanged; no second transfer after done
//   5 Reset mid-transfer: assert reset in busy cycle 3 ->
//     - next cycle q=00, busy=0, done=0; no done pulse follows
//   6 Back-to-back: start held high through done ->
//     - second transfer begins the cycle after done
//     - busy pattern 8 high, 1 low, 8 high; done pulses twice

Source files
------------

// File: rtl/shift_reg_n.sv
// Parametrised WIDTH-bit shift register with hold/shift/load modes.
// It also has an LSB-first serial transfer sequencer with a busy/done handshake.
module shift_reg_n #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= RESET_VAL;
      cnt   <= '0;
    end else begin
      state <= state_next;
      q     <= q_next;
      cnt   <= cnt_next;
    end
  end

  // The counter is cleared on the last shift, so it never wraps inside a transfer.
  always_comb begin
    state_next = state;
    q_next     = q;
    cnt_next   = cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
          if (en) begin
            case (mode)
              MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
              MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
              MODE_LOAD: q_next = d;
              MODE_HOLD: q_next = q;
              default:   q_next = q;
            endcase
          end
        end
      end
      SHIFT: begin
        q_next = {sin_l, q[WIDTH-1:1]};
        if (cnt == LAST_CNT) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign sout = q[0];
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
